mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory stage of the 5-stage RV32I pipeline; sits directly downstream of EX_stage. Latches EX results
//  in an internal EX/MEM register, performs loads/stores on a req/ready data-memory bus with byte-lane
//  strobes and load sign/zero extension, and presents registered results to write-back. Stalls upstream
//  while a memory access is outstanding; aborts accesses on misalignment or timeout.
// PARAMETERS
//  MAX_WAIT  15  cycles a request may stay un-acked before abort (>=1)
// PORTS
//  clk            in   1   system clock, rising edge
//  rst            in   1   asynchronous, active-high reset
//  ex_valid       in   1   EX slot holds a real instruction
//  ex_alu_result  in   32  ALU result / effective address
//  ex_store_data  in   32  rs2 value for stores
//  ex_func3       in   3   load/store width and sign (RV32I encoding)
//  ex_rd_addr     in   5   destination register
//  ex_reg_write   in   1   instruction writes rd
//  ex_mem_read    in   1   load
//  ex_mem_write   in   1   store
//  ex_mem_to_reg  in   1   rd gets load data, not ALU result
//  stall          out  1   hold IF/ID/EX and ID_EX this cycle
//  dmem_req       out  1   bus request
//  dmem_we        out  1   1 = write
//  dmem_addr      out  32  word-aligned address ({addr[31:2],2'b00})
//  dmem_wstrb     out  4   byte-lane write enables
//  dmem_wdata     out  32  lane-replicated store data
//  dmem_rdata     in   32  read data, valid when dmem_ready
//  dmem_ready     in   1   access complete this cycle
//  mem_rd_addr    out  5   rd of instruction in MEM (hazard/forwarding)
//  mem_reg_write  out  1   s_valid & s_reg_write (forwarding qualifier)
//  mem_is_load    out  1   s_valid & s_mem_read (load-use detect)
//  wb_valid       out  1   registered: WB slot valid
//  wb_reg_write   out  1   registered: write rd in WB
//  wb_rd_addr     out  5   registered: rd
//  wb_data        out  32  registered: extended load data or ALU result
//  misalign       out  1   one-cycle pulse: misaligned access dropped
//  bus_err        out  1   one-cycle pulse: access aborted at MAX_WAIT
// BEHAVIOUR
//  Reset (async): EX/MEM reg, WB reg, FSM, counter cleared; every output 0; dmem_req drops immediately.
//  EX/MEM reg (s_*): loads ex_* on each edge where !stall; holds while stalled.
//  Misalign: LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]!=0 -> no request, retire with reg_write=0,
//   misalign pulses on retire edge. Undefined func3 for a load/store is treated as misaligned.
//  dmem_req = s_valid & (s_mem_read|s_mem_write) & !misaligned; dmem_we = s_mem_write; comb from s_*.
//  Zero-wait: dmem_ready in same cycle as dmem_req completes the access; stall=0.
//  stall = dmem_req & !dmem_ready & !timeout.
//  FSM: IDLE -> WAIT when dmem_req & !dmem_ready; WAIT -> IDLE on dmem_ready or when wait_cnt==MAX_WAIT-1
//   (timeout). wait_cnt ($clog2(MAX_WAIT+1) bits) clears in IDLE, increments each WAIT cycle.
//  Timeout: request dropped, instruction retires with wb_reg_write=0, bus_err pulses; ready and timeout
//   in the same cycle -> ready wins (normal completion, no bus_err).
//  Stores: SB strobe 0001<<addr[1:0], data {4{rs2[7:0]}}; SH 0011<<addr[1:0], {2{rs2[15:0]}}; SW 1111.
//   Loads: dmem_wstrb=0.
//  Loads: lane = rdata >> (8*addr[1:0]); LB/LH sign-extend, LBU/LHU zero-extend, LW as-is.
//  WB reg: on edge with !stall, wb_* <= s_* (wb_data = s_mem_to_reg ? ext_load : s_alu_result);
//   on edge with stall, wb_valid=0, wb_reg_write=0 (bubble). Latency EX->WB outputs: 1 cycle + waits.
//  wb_reg_write = s_valid & s_reg_write & !misaligned & !timeout. Writes to x0 pass through (RF ignores).
//  EX flush does not affect this stage (instruction in MEM is older than the branch).
// STRUCTURE
//  Shared package rv32i_pkg: FUNCT3_LB/LH/LW/LBU/LHU/SB/SH/SW, state enum IDLE/WAIT.
//  One sub-module: load_store_align (comb: wstrb/wdata lane steering, misalign check, load extension).
// TESTING
//  ALU op, x5<=0x1234, no mem -> wb_data=0x00001234, wb_reg_write=1 next edge, dmem_req=0, stall=0.
//  SB addr 0x103 rs2=0x000000AB, ready same cycle -> wstrb=1000, wdata=0xABABABAB, addr=0x100, stall=0.
//  LB addr 0x102, rdata=0x0080FF00, ready after 3 cycles -> stall 3 cycles, wb_data=0xFFFFFF80 after.
//  LW addr 0x202 -> no dmem_req, misalign pulse, wb_valid=1 wb_reg_write=0.
//  LW with dmem_ready held 0 (MAX_WAIT=15) -> stall 14 cycles, bus_err pulse, retire with reg_write=0.
//  rst asserted during WAIT -> dmem_req, stall, wb_* to 0 immediately; next load starts cleanly.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings for the memory stage: load/store funct3 values
// and the memory-access FSM state type.
package rv32i_pkg;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/load_store_align.sv
// Combinational byte-lane steering for stores, alignment check, and
// load-lane extraction with sign/zero extension.
module load_store_align
  import rv32i_pkg::*;
(
  input  logic [1:0]  addr_i,
  input  logic [2:0]  func3_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic        misaligned_o,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);

  logic [31:0] lane;

  // Undefined widths are rejected the same way as misaligned addresses.
  always_comb begin
    misaligned_o = 1'b0;
    if (mem_read_i) begin
      case (func3_i)
        FUNCT3_LB, FUNCT3_LBU: misaligned_o = 1'b0;
        FUNCT3_LH, FUNCT3_LHU: misaligned_o = addr_i[0];
        FUNCT3_LW:             misaligned_o = |addr_i;
        default:               misaligned_o = 1'b1;
      endcase
    end else if (mem_write_i) begin
      case (func3_i)
        FUNCT3_SB: misaligned_o = 1'b0;
        FUNCT3_SH: misaligned_o = addr_i[0];
        FUNCT3_SW: misaligned_o = |addr_i;
        default:   misaligned_o = 1'b1;
      endcase
    end
  end

  always_comb begin
    wstrb_o = '0;
    wdata_o = store_data_i;
    if (mem_write_i) begin
      case (func3_i)
        FUNCT3_SB: begin
          wstrb_o = 4'b0001 << addr_i;
          wdata_o = {4{store_data_i[7:0]}};
        end
        FUNCT3_SH: begin
          wstrb_o = 4'b0011 << addr_i;
          wdata_o = {2{store_data_i[15:0]}};
        end
        FUNCT3_SW: wstrb_o = 4'b1111;
        default:   wstrb_o = '0;
      endcase
    end
  end

  assign lane = rdata_i >> {addr_i, 3'b000};

  always_comb begin
    load_data_o = lane;
    case (func3_i)
      FUNCT3_LB:  load_data_o = {{24{lane[7]}}, lane[7:0]};
      FUNCT3_LH:  load_data_o = {{16{lane[15]}}, lane[15:0]};
      FUNCT3_LBU: load_data_o = {24'b0, lane[7:0]};
      FUNCT3_LHU: load_data_o = {16'b0, lane[15:0]};
      default:    load_data_o = lane;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: EX/MEM register, req/ready data-memory access with
// timeout abort, and registered write-back outputs.
module mem_stage #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic [2:0]  ex_func3,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic        ex_mem_to_reg,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic [4:0]  mem_rd_addr,
  output logic        mem_reg_write,
  output logic        mem_is_load,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [4:0]  wb_rd_addr,
  output logic [31:0] wb_data,
  output logic        misalign,
  output logic        bus_err
);
  import rv32i_pkg::*;

  localparam int unsigned       CNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_WAIT - 1);

  logic        s_valid_q, s_reg_write_q, s_mem_read_q, s_mem_write_q, s_mem_to_reg_q;
  logic [31:0] s_alu_q, s_store_q;
  logic [2:0]  s_func3_q;
  logic [4:0]  s_rd_q;

  logic        wb_valid_q, wb_reg_write_q, misalign_q, bus_err_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        align_mis, misaligned, timeout, abort;
  logic [31:0] load_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_valid_q      <= 1'b0;
      s_alu_q        <= '0;
      s_store_q      <= '0;
      s_func3_q      <= '0;
      s_rd_q         <= '0;
      s_reg_write_q  <= 1'b0;
      s_mem_read_q   <= 1'b0;
      s_mem_write_q  <= 1'b0;
      s_mem_to_reg_q <= 1'b0;
    end else if (!stall) begin
      s_valid_q      <= ex_valid;
      s_alu_q        <= ex_alu_result;
      s_store_q      <= ex_store_data;
      s_func3_q      <= ex_func3;
      s_rd_q         <= ex_rd_addr;
      s_reg_write_q  <= ex_reg_write;
      s_mem_read_q   <= ex_mem_read;
      s_mem_write_q  <= ex_mem_write;
      s_mem_to_reg_q <= ex_mem_to_reg;
    end
  end

  load_store_align u_align (
    .addr_i       (s_alu_q[1:0]),
    .func3_i      (s_func3_q),
    .mem_read_i   (s_mem_read_q),
    .mem_write_i  (s_mem_write_q),
    .store_data_i (s_store_q),
    .rdata_i      (dmem_rdata),
    .misaligned_o (align_mis),
    .wstrb_o      (dmem_wstrb),
    .wdata_o      (dmem_wdata),
    .load_data_o  (load_data)
  );

  assign misaligned    = s_valid_q & (s_mem_read_q | s_mem_write_q) & align_mis;
  assign dmem_req      = s_valid_q & (s_mem_read_q | s_mem_write_q) & ~align_mis;
  assign dmem_we       = s_mem_write_q;
  assign dmem_addr     = {s_alu_q[31:2], 2'b00};
  assign timeout       = dmem_req & (cnt_q == CNT_LAST);
  assign abort         = timeout & ~dmem_ready;
  assign stall         = dmem_req & ~dmem_ready & ~timeout;
  assign mem_rd_addr   = s_rd_q;
  assign mem_reg_write = s_valid_q & s_reg_write_q;
  assign mem_is_load   = s_valid_q & s_mem_read_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter also advances on the IDLE->WAIT edge, so it holds the number
  // of cycles already spent un-acked; timeout lands on the MAX_WAIT-th cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      IDLE:    if (stall)  state_d = WAIT;
      WAIT:    if (!stall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (stall) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_rd_q        <= '0;
      wb_data_q      <= '0;
      misalign_q     <= 1'b0;
      bus_err_q      <= 1'b0;
    end else if (stall) begin
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      misalign_q     <= 1'b0;
      bus_err_q      <= 1'b0;
    end else begin
      wb_valid_q     <= s_valid_q;
      wb_reg_write_q <= s_valid_q & s_reg_write_q & ~misaligned & ~abort;
      wb_rd_q        <= s_rd_q;
      wb_data_q      <= s_mem_to_reg_q ? load_data : s_alu_q;
      misalign_q     <= misaligned;
      bus_err_q      <= abort;
    end
  end

  assign wb_valid     = wb_valid_q;
  assign wb_reg_write = wb_reg_write_q;
  assign wb_rd_addr   = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign misalign     = misalign_q;
  assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, stores, loads with waits,
// misalignment, timeout abort and reset during an outstanding access.
module tb_mem_stage;

  logic        clk, rst;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic [31:0] ex_alu_result, ex_store_data, dmem_rdata, dmem_addr, dmem_wdata, wb_data;
  logic [2:0]  ex_func3;
  logic [4:0]  ex_rd_addr, mem_rd_addr, wb_rd_addr;
  logic        stall, dmem_req, dmem_we, dmem_ready, mem_reg_write, mem_is_load;
  logic        wb_valid, wb_reg_write, misalign, bus_err;
  logic [3:0]  dmem_wstrb;

  int checks   = 0;
  int failures = 0;

  mem_stage #(.MAX_WAIT(15)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_func3(ex_func3), .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready), .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write),
    .mem_is_load(mem_is_load), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
    .wb_rd_addr(wb_rd_addr), .wb_data(wb_data), .misalign(misalign), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, 32'(obs), 32'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] sd,
                       input logic [2:0] f3, input logic [4:0] rd, input logic rw,
                       input logic mr, input logic mw, input logic m2r);
    ex_valid = v; ex_alu_result = alu; ex_store_data = sd; ex_func3 = f3;
    ex_rd_addr = rd; ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw;
    ex_mem_to_reg = m2r;
  endtask

  task automatic bubble();
    drive(1'b0, 32'h0, 32'h0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;
    bubble();
    #12;
    chk1("rst_stall", stall, 1'b0);
    chk1("rst_req", dmem_req, 1'b0);
    chk1("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_wb_data", wb_data, 32'h0);
    chk1("rst_misalign", misalign, 1'b0);
    chk1("rst_bus_err", bus_err, 1'b0);
    rst = 1'b0;

    // ALU op x5 <= 0x1234
    drive(1'b1, 32'h0000_1234, 32'h0, 3'b000, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk1("alu_req", dmem_req, 1'b0);
    chk1("alu_stall", stall, 1'b0);
    chk("alu_mem_rd", 32'(mem_rd_addr), 32'd5);
    chk1("alu_mem_rw", mem_reg_write, 1'b1);
    bubble();
    tick();
    chk1("alu_wb_valid", wb_valid, 1'b1);
    chk1("alu_wb_rw", wb_reg_write, 1'b1);
    chk("alu_wb_rd", 32'(wb_rd_addr), 32'd5);
    chk("alu_wb_data", wb_data, 32'h0000_1234);

    // SB 0x103, zero-wait
    drive(1'b1, 32'h0000_0103, 32'h0000_00AB, 3'b000, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    dmem_ready = 1'b1;
    #1;
    chk1("sb_req", dmem_req, 1'b1);
    chk1("sb_we", dmem_we, 1'b1);
    chk("sb_wstrb", 32'(dmem_wstrb), 32'h8);
    chk("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
    chk("sb_addr", dmem_addr, 32'h0000_0100);
    chk1("sb_stall", stall, 1'b0);
    bubble();
    tick();
    dmem_ready = 1'b0;
    chk1("sb_wb_valid", wb_valid, 1'b1);
    chk1("sb_wb_rw", wb_reg_write, 1'b0);

    // LB 0x102, ready after 3 stalled cycles
    drive(1'b1, 32'h0000_0102, 32'h0, 3'b000, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    bubble();
    chk1("lb_req", dmem_req, 1'b1);
    chk1("lb_is_load", mem_is_load, 1'b1);
    chk("lb_wstrb", 32'(dmem_wstrb), 32'h0);
    chk1("lb_stall1", stall, 1'b1);
    tick();
    chk1("lb_stall2", stall, 1'b1);
    chk1("lb_bubble", wb_valid, 1'b0);
    tick();
    chk1("lb_stall3", stall, 1'b1);
    tick();
    dmem_ready = 1'b1;
    dmem_rdata = 32'h0080_FF00;
    #1;
    chk1("lb_stall_rel", stall, 1'b0);
    tick();
    dmem_ready = 1'b0;
    chk1("lb_wb_valid", wb_valid, 1'b1);
    chk1("lb_wb_rw", wb_reg_write, 1'b1);
    chk("lb_wb_rd", 32'(wb_rd_addr), 32'd7);
    chk("lb_wb_data", wb_data, 32'hFFFF_FF80);

    // LW 0x202 misaligned
    drive(1'b1, 32'h0000_0202, 32'h0, 3'b010, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    bubble();
    chk1("mis_req", dmem_req, 1'b0);
    chk1("mis_stall", stall, 1'b0);
    tick();
    chk1("mis_pulse", misalign, 1'b1);
    chk1("mis_wb_valid", wb_valid, 1'b1);
    chk1("mis_wb_rw", wb_reg_write, 1'b0);
    chk1("mis_bus_err", bus_err, 1'b0);
    tick();
    chk1("mis_pulse_end", misalign, 1'b0);

    // LW 0x300 never acked -> timeout
    drive(1'b1, 32'h0000_0300, 32'h0, 3'b010, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    bubble();
    n = 0;
    while (stall === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    chk("to_stall_cycles", 32'(n), 32'd14);
    chk1("to_req_last", dmem_req, 1'b1);
    chk1("to_no_err_yet", bus_err, 1'b0);
    tick();
    chk1("to_bus_err", bus_err, 1'b1);
    chk1("to_wb_valid", wb_valid, 1'b1);
    chk1("to_wb_rw", wb_reg_write, 1'b0);
    chk1("to_req_drop", dmem_req, 1'b0);
    tick();
    chk1("to_bus_err_end", bus_err, 1'b0);

    // reset while waiting
    drive(1'b1, 32'h0000_0400, 32'h0, 3'b010, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    bubble();
    tick();
    chk1("rw_stall_pre", stall, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk1("rw_req", dmem_req, 1'b0);
    chk1("rw_stall", stall, 1'b0);
    chk1("rw_wb_valid", wb_valid, 1'b0);
    chk("rw_wb_data", wb_data, 32'h0);
    chk("rw_mem_rd", 32'(mem_rd_addr), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // LH 0x102 after reset, zero-wait, sign-extended
    drive(1'b1, 32'h0000_0102, 32'h0, 3'b001, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    dmem_ready = 1'b1;
    dmem_rdata = 32'h8001_0000;
    #1;
    chk1("lh_req", dmem_req, 1'b1);
    chk1("lh_stall", stall, 1'b0);
    chk("lh_addr", dmem_addr, 32'h0000_0100);
    bubble();
    tick();
    dmem_ready = 1'b0;
    chk1("lh_wb_rw", wb_reg_write, 1'b1);
    chk("lh_wb_data", wb_data, 32'hFFFF_8001);

    // SH 0x102
    drive(1'b1, 32'h0000_0102, 32'h1234_ABCD, 3'b001, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    dmem_ready = 1'b1;
    #1;
    chk("sh_wstrb", 32'(dmem_wstrb), 32'hC);
    chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
    bubble();
    tick();
    dmem_ready = 1'b0;

    // LBU 0x101 zero-extended
    drive(1'b1, 32'h0000_0101, 32'h0, 3'b100, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    dmem_ready = 1'b1;
    dmem_rdata = 32'h0000_AB00;
    #1;
    bubble();
    tick();
    dmem_ready = 1'b0;
    chk("lbu_wb_data", wb_data, 32'h0000_00AB);

    // undefined load width treated as misaligned
    drive(1'b1, 32'h0000_0100, 32'h0, 3'b011, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    bubble();
    chk1("badf3_req", dmem_req, 1'b0);
    tick();
    chk1("badf3_misalign", misalign, 1'b1);
    chk1("badf3_wb_rw", wb_reg_write, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
